debouncer_butoane: RTL and testbench
====================================

// Module: debouncer_butoane
// PURPOSE
//  Upstream stage of the square/circle position controller. Takes the four raw, asynchronous
//  Basys-3 push-buttons and emits clean single-cycle press pulses buton_apasatL/R/U/D.
//  Per button: 2-FF synchronizer, tick-based debounce, rising-edge pulse, optional auto-repeat.
//  Every pulse is one step request to the position controller.
// PARAMETERS
//  TICK_DIV   148500  clk cycles per debounce/repeat tick (1 ms at 148.5 MHz)
//  DEB_TICKS  10      consecutive disagreeing ticks needed to accept a new level (10 ms)
//  REP_DELAY  400     ticks from press pulse to first repeat pulse (auto-repeat only)
//  REP_RATE   100     ticks between subsequent repeat pulses (auto-repeat only)
// PORTS
//  clk_148Mhz     in   1  system pixel clock; the only clock
//  reset          in   1  synchronous, active-high reset
//  btnL_raw       in   1  raw left button, asynchronous, active-high
//  btnR_raw       in   1  raw right button
//  btnU_raw       in   1  raw up button
//  btnD_raw       in   1  raw down button
//  buton_apasatL  out  1  left step pulse, 1 clk wide, registered
//  buton_apasatR  out  1  right step pulse
//  buton_apasatU  out  1  up step pulse
//  buton_apasatD  out  1  down step pulse
//  stare_stabila  out  4  debounced levels {D,U,R,L}, registered
// BEHAVIOUR
//  - Reset (sync, on clock edge with reset=1): sync FFs, prescaler, all counters, stable levels,
//    FSMs and all outputs go to 0. Reset overrides every other action in that cycle.
//  - Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for exactly one cycle when count==TICK_DIV-1.
//    All four buttons share this prescaler. Counter width is $clog2(TICK_DIV).
//  - Synchronizer: two flops per button. The synced value lags the raw input by 2 clk.
//  - Debounce, per button, with stable level s and counter dcnt:
//    - Evaluated only on tick.
//    - Tick with sync==s: dcnt<=0.
//    - Tick with sync!=s and dcnt==DEB_TICKS-1: s<=sync, dcnt<=0.
//    - Otherwise: dcnt<=dcnt+1.
//    - Any single agreeing tick restarts the count. dcnt saturates logically and never wraps.
//  - Pulse generation:
//    - Press pulse: buton_apasatX=1 in the clk cycle right after s changes 0->1.
//    - Release (s 1->0) never pulses.
//  - Per-button FSM:
//    - IDLE: waits for s 0->1, then emits a press pulse and goes to HOLD.
//    - HOLD and REPEAT: exist only with the macro; see CONFIGURATION.
//    - s 1->0 from any state: go to IDLE, clear rcnt, no pulse.
//  - Buttons are independent. Simultaneous pulses on several outputs in the same cycle are legal;
//    the downstream controller resolves opposing directions.
//  - Button held through reset: after reset deasserts s=0, so one press pulse follows after
//    DEB_TICKS ticks.
//  - Every output pulse is exactly 1 clk wide; no two pulses from one button are less than
//    one tick apart.
// CONFIGURATION
//  - Macro BUTOANE_AUTOREPEAT_EN.
//  - Defined: per-button FSM IDLE -> HOLD -> REPEAT, with repeat counter rcnt,
//    width $clog2(max(REP_DELAY,REP_RATE)).
//    - HOLD: rcnt increments on tick. At rcnt==REP_DELAY-1: pulse, rcnt<=0, go to REPEAT.
//    - REPEAT: rcnt increments on tick. At rcnt==REP_RATE-1: pulse, rcnt<=0, stay in REPEAT.
//  - Not defined: FSM is IDLE/PRESSED only and exactly one pulse is produced per debounced press.
//    REP_DELAY and REP_RATE are unused; rcnt logic is not synthesized.
// TESTING (sim params TICK_DIV=4, DEB_TICKS=3, REP_DELAY=5, REP_RATE=2; tick every 4 clk)
//  1 Reset: hold reset 10 clk with btnL_raw=1 -> all outputs 0 during reset;
//    after release, exactly one buton_apasatL pulse within 3 ticks + 2 clk (+<=4 clk phase).
//  2 Clean press: btnR_raw=1 for 6 ticks, then 0 (macro off) -> one 1-clk buton_apasatR pulse;
//    stare_stabila[1] rises, then falls 3 ticks after release; no other outputs toggle.
//  3 Bounce: btnU_raw toggles every 6 clk for 20 ticks, then 0 -> zero pulses;
//    stare_stabila[2] stays 0.
//  4 Auto-repeat (macro on): btnD_raw held; press pulse at tick t0 -> further pulses at
//    t0+5, +7, +9, +11, +13 ticks. Release after t0+14 -> no further pulses; FSM back in IDLE.
//  5 Simultaneous: btnL_raw and btnU_raw rise in the same clk -> buton_apasatL and buton_apasatU
//    pulse in the same cycle, once each (macro off).
//  6 Reset mid-repeat (macro on): assert reset 1 clk while in REPEAT -> outputs 0 next cycle;
//    with button still held, a fresh press pulse follows 3 ticks later, then the repeat
//    sequence restarts from REP_DELAY.

Source files
------------

// File: rtl/debouncer_butoane.sv
// Four-button debouncer: 2-FF sync, tick-based debounce and one-clock press pulses per button.
// Define BUTOANE_AUTOREPEAT_EN to add hold-to-repeat (REP_DELAY ticks, then every REP_RATE ticks).

module debouncer_lane #(
    parameter int DEB_TICKS = 10,
    parameter int REP_DELAY = 400,
    parameter int REP_RATE  = 100
) (
    input  logic clk_148Mhz,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic pulse,
    output logic level
);
    localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);

    logic [1:0]    sync_q;
    logic [DW-1:0] dcnt;

    // A single agreeing tick restarts the count; the level only moves after DEB_TICKS disagreeing ticks.
    always_ff @(posedge clk_148Mhz) begin
        if (reset) begin
            sync_q <= '0;
            dcnt   <= '0;
            level  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (tick) begin
                if (sync_q[1] == level) begin
                    dcnt <= '0;
                end else if (dcnt == DEB_LAST) begin
                    level <= sync_q[1];
                    dcnt  <= '0;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end
        end
    end

`ifdef BUTOANE_AUTOREPEAT_EN
    localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DELAY_LAST = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REP_RATE - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
    state_t        state;
    logic [RW-1:0] rcnt;

    always_ff @(posedge clk_148Mhz) begin
        if (reset) begin
            state <= IDLE;
            rcnt  <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (level) begin
                        pulse <= 1'b1;
                        rcnt  <= '0;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!level) begin
                        rcnt  <= '0;
                        state <= IDLE;
                    end else if (tick) begin
                        if (rcnt == DELAY_LAST) begin
                            pulse <= 1'b1;
                            rcnt  <= '0;
                            state <= REPEAT;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (!level) begin
                        rcnt  <= '0;
                        state <= IDLE;
                    end else if (tick) begin
                        if (rcnt == RATE_LAST) begin
                            pulse <= 1'b1;
                            rcnt  <= '0;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    typedef enum logic {IDLE, PRESSED} state_t;
    state_t state;

    always_ff @(posedge clk_148Mhz) begin
        if (reset) begin
            state <= IDLE;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (level) begin
                        pulse <= 1'b1;
                        state <= PRESSED;
                    end
                end
                PRESSED: begin
                    if (!level) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif
endmodule

module debouncer_butoane #(
    parameter int TICK_DIV  = 148500,
    parameter int DEB_TICKS = 10,
    parameter int REP_DELAY = 400,
    parameter int REP_RATE  = 100
) (
    input  logic       clk_148Mhz,
    input  logic       reset,
    input  logic       btnL_raw,
    input  logic       btnR_raw,
    input  logic       btnU_raw,
    input  logic       btnD_raw,
    output logic       buton_apasatL,
    output logic       buton_apasatR,
    output logic       buton_apasatU,
    output logic       buton_apasatD,
    output logic [3:0] stare_stabila
);
    localparam int NUM_LANES = 4;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]          pcnt;
    logic                   tick;
    logic [NUM_LANES-1:0]   btn_raw;
    logic [NUM_LANES-1:0]   pulse;

    // One shared prescaler keeps all four buttons on the same tick grid.
    assign tick = (pcnt == TICK_LAST);

    always_ff @(posedge clk_148Mhz) begin
        if (reset) pcnt <= '0;
        else       pcnt <= tick ? '0 : pcnt + 1'b1;
    end

    assign btn_raw = {btnD_raw, btnU_raw, btnR_raw, btnL_raw};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        debouncer_lane #(
            .DEB_TICKS(DEB_TICKS),
            .REP_DELAY(REP_DELAY),
            .REP_RATE (REP_RATE)
        ) u_lane (
            .clk_148Mhz(clk_148Mhz),
            .reset     (reset),
            .tick      (tick),
            .raw       (btn_raw[i]),
            .pulse     (pulse[i]),
            .level     (stare_stabila[i])
        );
    end

    assign {buton_apasatD, buton_apasatU, buton_apasatR, buton_apasatL} = pulse;
endmodule

// File: tb/tb_debouncer_butoane.sv
// Directed + random bench for debouncer_butoane, checked every cycle against a tick-level reference model.
// Honours BUTOANE_AUTOREPEAT_EN the same way the design does.

module tb_debouncer_butoane;
    localparam int TICK_DIV  = 4;
    localparam int DEB_TICKS = 3;
    localparam int REP_DELAY = 5;
    localparam int REP_RATE  = 2;

    logic       clk_148Mhz = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn = 4'b0;
    logic       buton_apasatL, buton_apasatR, buton_apasatU, buton_apasatD;
    logic [3:0] stare_stabila;
    logic [3:0] pulses;

    always #5 clk_148Mhz = ~clk_148Mhz;

    debouncer_butoane #(
        .TICK_DIV (TICK_DIV),
        .DEB_TICKS(DEB_TICKS),
        .REP_DELAY(REP_DELAY),
        .REP_RATE (REP_RATE)
    ) dut (
        .clk_148Mhz   (clk_148Mhz),
        .reset        (reset),
        .btnL_raw     (btn[0]),
        .btnR_raw     (btn[1]),
        .btnU_raw     (btn[2]),
        .btnD_raw     (btn[3]),
        .buton_apasatL(buton_apasatL),
        .buton_apasatR(buton_apasatR),
        .buton_apasatU(buton_apasatU),
        .buton_apasatD(buton_apasatD),
        .stare_stabila(stare_stabila)
    );

    assign pulses = {buton_apasatD, buton_apasatU, buton_apasatR, buton_apasatL};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    // Reference model: works on edge counts since reset and a window of tick samples.
    logic [3:0] m_s = '0, m_pulse = '0, m_rose = '0, h1 = '0, h2 = '0;
    logic [3:0] samp_q[$];
    int esr = 0;
    int since[4];
    int d[4];

    // Observation bookkeeping for directed checks.
    int cnt[4];
    int first_cyc[4];
    logic [3:0] seen_s;
    int pulse_d_q[$];

    task automatic model_edge();
        logic [3:0] sync, s_pre, rose;
        bit all_dis;
        if (reset) begin
            m_s = '0; m_pulse = '0; m_rose = '0; esr = 0;
            samp_q.delete();
            for (int b = 0; b < 4; b++) begin since[b] = 0; d[b] = 0; end
        end else begin
            esr++;
            sync    = (esr >= 3) ? h2 : 4'b0;
            s_pre   = m_s;
            m_pulse = m_rose;
            rose    = '0;
            if (esr % TICK_DIV == 0) begin
                samp_q.push_back(sync);
                if (samp_q.size() > DEB_TICKS) void'(samp_q.pop_front());
                for (int b = 0; b < 4; b++) begin
                    since[b]++;
`ifdef BUTOANE_AUTOREPEAT_EN
                    if (s_pre[b]) begin
                        d[b]++;
                        if (d[b] >= REP_DELAY && (d[b] - REP_DELAY) % REP_RATE == 0) m_pulse[b] = 1'b1;
                    end
`endif
                    if (since[b] >= DEB_TICKS) begin
                        all_dis = 1'b1;
                        for (int j = 0; j < samp_q.size(); j++)
                            if (samp_q[j][b] == s_pre[b]) all_dis = 1'b0;
                        if (all_dis) begin
                            m_s[b]   = ~s_pre[b];
                            since[b] = 0;
                            if (!s_pre[b]) begin rose[b] = 1'b1; d[b] = 0; end
                        end
                    end
                end
            end
            m_rose = rose;
        end
        h2 = h1;
        h1 = btn;
    endtask

    task automatic cyc();
        @(posedge clk_148Mhz);
        model_edge();
        @(negedge clk_148Mhz);
        cyc_n++;
        n_checks++;
        assert ({pulses, stare_stabila} === {m_pulse, m_s}) else begin
            n_fail++;
            $error("FAIL cycle_check cyc=%0d observed pulses/stable=%b/%b expected=%b/%b",
                   cyc_n, pulses, stare_stabila, m_pulse, m_s);
        end
        for (int b = 0; b < 4; b++) begin
            if (pulses[b] === 1'b1) begin
                if (cnt[b] == 0) first_cyc[b] = cyc_n;
                cnt[b]++;
            end
        end
        if (pulses[3] === 1'b1) pulse_d_q.push_back(cyc_n);
        seen_s |= stare_stabila;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clr();
        for (int b = 0; b < 4; b++) begin cnt[b] = 0; first_cyc[b] = -1; end
        seen_s = '0;
        pulse_d_q.delete();
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        clr();
        // 1: reset held with left button pressed
        btn = 4'b0001;
        reset = 1'b1;
        run(10);
        chk("reset_outputs_zero", int'({pulses, stare_stabila}), 0);
        chk("reset_no_pulses", cnt[0] + cnt[1] + cnt[2] + cnt[3], 0);
        reset = 1'b0;
        clr();
        run(18);
        chk("post_reset_L_pulse", cnt[0], 1);
        btn = 4'b0; run(40);
        chk("post_reset_L_total", cnt[0], 1);

        // 2: clean right press
        clr();
        btn[1] = 1'b1; run(24);
        btn[1] = 1'b0; run(40);
        chk("clean_R_pulses", cnt[1], 1);
        chk("clean_others", cnt[0] + cnt[2] + cnt[3], 0);
        chk("clean_R_level_seen", int'(seen_s[1]), 1);
        chk("clean_R_level_end", int'(stare_stabila[1]), 0);

        // 3: bouncing up button never settles
        clr();
        for (int k = 0; k < 14; k++) begin btn[2] = ~btn[2]; run(6); end
        btn[2] = 1'b0; run(40);
        chk("bounce_U_pulses", cnt[2], 0);
        chk("bounce_U_level", int'(seen_s[2]), 0);

        // 5: simultaneous left and up
        clr();
        btn = 4'b0101; run(60);
        btn = 4'b0; run(40);
`ifndef BUTOANE_AUTOREPEAT_EN
        chk("simul_L_count", cnt[0], 1);
        chk("simul_U_count", cnt[2], 1);
`endif
        chk("simul_same_cycle", first_cyc[0], first_cyc[2]);

`ifdef BUTOANE_AUTOREPEAT_EN
        // 4: auto-repeat cadence on down button
        clr();
        btn[3] = 1'b1;
        for (int i = 0; i < 200 && pulse_d_q.size() < 6; i++) cyc();
        chk("repeat_count", pulse_d_q.size(), 6);
        if (pulse_d_q.size() == 6) begin
            chk("repeat_first_gap", pulse_d_q[1] - pulse_d_q[0], REP_DELAY * TICK_DIV);
            for (int k = 2; k < 6; k++)
                chk("repeat_rate_gap", pulse_d_q[k] - pulse_d_q[k-1], REP_RATE * TICK_DIV);
        end
        btn[3] = 1'b0;
        for (int i = 0; i < 100 && stare_stabila[3] !== 1'b0; i++) cyc();
        chk("repeat_release_level", int'(stare_stabila[3]), 0);
        clr();
        run(40);
        chk("repeat_after_release", cnt[3], 0);

        // 6: reset while repeating, button still held
        clr();
        btn[3] = 1'b1;
        for (int i = 0; i < 200 && pulse_d_q.size() < 3; i++) cyc();
        chk("midrep_reached", pulse_d_q.size(), 3);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("midrep_reset_out", int'({pulses, stare_stabila}), 0);
        clr();
        run(16);
        chk("midrep_fresh_press", cnt[3], 1);
        run(16);
        chk("midrep_no_rate_gap", cnt[3], 1);
        run(2);
        chk("midrep_delay_restart", cnt[3], 2);
        btn[3] = 1'b0; run(40);
`else
        // Held button, no auto-repeat: exactly one pulse
        clr();
        btn[3] = 1'b1; run(120);
        btn[3] = 1'b0; run(40);
        chk("hold_single_pulse", cnt[3], 1);
`endif

        // Random stretches, occasional one-cycle reset
        for (int i = 0; i < 200; i++) begin
            btn = 4'($urandom);
            if ($urandom_range(0, 24) == 0) begin
                reset = 1'b1; cyc(); reset = 1'b0;
            end
            run($urandom_range(1, 40));
        end
        btn = 4'b0; run(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
